// File: rtl/srm_pkg.sv
// Shared definitions for the Simple RISC Machine: state encoding, opcode/op
// codes, register-select and writeback-select codes, and DECODE dispatch.
// Optional feature macro: SRM_HALT_EN (adds the absorbing HALT state).
package srm_pkg;

   localparam logic [1:0] SX_SEL = 2'b10;
   localparam logic [1:0] C_SEL  = 2'b00;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_HLT = 3'b111;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b100;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b001;

   typedef enum logic [3:0] {
      S_WAIT,
      S_DECODE,
      S_WR_IMM,
      S_GET_A,
      S_GET_B,
      S_OPERATE,
      S_COMPARE,
      S_WR_REG
`ifdef SRM_HALT_EN
      , S_HALT
`endif
   } state_t;

   // First state after DECODE for a given instruction; illegal codes return to WAIT.
   function automatic state_t dispatch(input logic [2:0] opcode, input logic [1:0] op);
      state_t nxt;
      nxt = S_WAIT;
      case (opcode)
         OPC_MOV: begin
            if (op == OP_MOV_IMM)      nxt = S_WR_IMM;
            else if (op == OP_MOV_REG) nxt = S_GET_B;
            else                       nxt = S_WAIT;
         end
         OPC_ALU: begin
            if (op == OP_MVN) nxt = S_GET_B;
            else              nxt = S_GET_A;
         end
`ifdef SRM_HALT_EN
         OPC_HLT: nxt = S_HALT;
`endif
         default: nxt = S_WAIT;
      endcase
      return nxt;
   endfunction

   // MOV-reg and MVN pass B through the ALU, so the A operand is forced to zero.
   function automatic logic a_is_zero(input logic [2:0] opcode, input logic [1:0] op);
      return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
             ((opcode == OPC_ALU) && (op == OP_MVN));
   endfunction

endpackage

// File: rtl/srm_controller_if.sv
// Control bus between the instruction decoder/datapath and srm_controller.
// Handshake: the decoder raises s while w=1 to start the instruction held on
// opcode/op; the controller accepts it on that rising edge, drops w, and keeps
// w low until the instruction finishes. opcode/op must stay stable from the
// accepting edge until w is high again. s is ignored while w=0.
interface srm_controller_if;
   import srm_pkg::*;

   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       write;
   logic       loada;
   logic       loadb;
   logic       asel;
   logic       bsel;
   logic       loadc;
   logic       loads;
   state_t     dbg_state;

   modport master (
      input  s, opcode, op,
      output w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, dbg_state
   );

   modport slave (
      output s, opcode, op,
      input  w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, dbg_state
   );

endinterface

// File: rtl/srm_controller.sv
// Multi-cycle control FSM of the Simple RISC Machine. One instruction per
// accepted start; all outputs are Moore, decoded from the state register.
// Optional feature macro: SRM_HALT_EN (opcode 111 enters an absorbing HALT).
module srm_controller
   import srm_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   srm_controller_if.master  bus
);

   state_t state_q, state_d;
   logic   a_zero_q, a_zero_d;

   // State register and the captured "A operand is zero" flag; sync active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_WAIT;
         a_zero_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_zero_q <= a_zero_d;
      end
   end

   // Next-state sequencing; unreachable encodings fall back to WAIT.
   always_comb begin
      state_d  = S_WAIT;
      a_zero_d = a_zero_q;
      case (state_q)
         S_WAIT:    state_d = bus.s ? S_DECODE : S_WAIT;
         S_DECODE: begin
            state_d  = dispatch(bus.opcode, bus.op);
            a_zero_d = a_is_zero(bus.opcode, bus.op);
         end
         S_WR_IMM:  state_d = S_WAIT;
         S_GET_A:   state_d = S_GET_B;
         S_GET_B: begin
            if ((bus.opcode == OPC_ALU) && (bus.op == OP_CMP)) state_d = S_COMPARE;
            else                                               state_d = S_OPERATE;
         end
         S_OPERATE: state_d = S_WR_REG;
         S_COMPARE: state_d = S_WAIT;
         S_WR_REG:  state_d = S_WAIT;
`ifdef SRM_HALT_EN
         S_HALT:    state_d = S_HALT;
`endif
         default:   state_d = S_WAIT;
      endcase
   end

   // Moore output decode; everything not named by a state stays 0.
   always_comb begin
      bus.w     = 1'b0;
      bus.nsel  = NSEL_NONE;
      bus.vsel  = C_SEL;
      bus.write = 1'b0;
      bus.loada = 1'b0;
      bus.loadb = 1'b0;
      bus.asel  = 1'b0;
      bus.bsel  = 1'b0;
      bus.loadc = 1'b0;
      bus.loads = 1'b0;
      case (state_q)
         S_WAIT:    bus.w = 1'b1;
         S_WR_IMM: begin
            bus.nsel  = NSEL_RN;
            bus.vsel  = SX_SEL;
            bus.write = 1'b1;
         end
         S_GET_A: begin
            bus.nsel  = NSEL_RN;
            bus.loada = 1'b1;
         end
         S_GET_B: begin
            bus.nsel  = NSEL_RM;
            bus.loadb = 1'b1;
         end
         S_OPERATE: begin
            bus.loadc = 1'b1;
            bus.asel  = a_zero_q;
         end
         S_COMPARE: bus.loads = 1'b1;
         S_WR_REG: begin
            bus.nsel  = NSEL_RD;
            bus.vsel  = C_SEL;
            bus.write = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.dbg_state = state_q;

endmodule
